instr_fetch: RTL and testbench

- Fetch stage that sits directly upstream of MEM, the 32x8 synchronous memory.
- Drives MEM's read address and enable from a 5-bit program counter and captures the returned byte into an instruction register.
- Presents the instruction to the decode/controller stage over a valid/ready handshake.
- Supports PC redirect (jump/branch) and run/stop control.

---
 rtl/instr_fetch_if.sv | 33 +++
 rtl/instr_fetch.sv | 76 +++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Handshake and memory bus between the fetch stage, its instruction memory and the decode stage.
// master = fetch stage; slave = memory/decoder side.
interface instr_fetch_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst_data;
    logic [2:0]    inst_opcode;
    logic [AW-1:0] inst_operand;
    logic [AW-1:0] inst_pc;

    modport master (
        output mem_en, mem_we, mem_addr,
        input  mem_dout,
        output inst_valid,
        input  inst_ready,
        output inst_data, inst_opcode, inst_operand, inst_pc
    );

    modport slave (
        input  mem_en, mem_we, mem_addr,
        output mem_dout,
        input  inst_valid,
        output inst_ready,
        input  inst_data, inst_opcode, inst_operand, inst_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one byte per instruction from a synchronous memory
// and presents it downstream over valid/ready, with PC redirect and run/stop control.
module instr_fetch #(
    parameter int            AW       = 5,
    parameter int            DW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic [AW-1:0] pc,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, VALID} state_t;

    state_t        state;
    state_t        state_next;
    logic          mem_en;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            inst_data <= '0;
            inst_pc   <= '0;
        end else begin
            state <= state_next;
            // A redirect discards any in-flight capture so stale bytes never surface.
            if (redirect_valid) begin
                pc <= redirect_addr;
            end else if (state == CAPTURE) begin
                inst_data <= bus.mem_dout;
                inst_pc   <= pc;
                pc        <= pc + AW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        inst_valid = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                mem_en     = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = VALID;
            end
            VALID: begin
                inst_valid = 1'b1;
                if (bus.inst_ready) state_next = run ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (redirect_valid) state_next = run ? FETCH : IDLE;
    end

    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = 1'b0;
    assign bus.mem_addr     = pc;
    assign bus.inst_valid   = inst_valid;
    assign bus.inst_data    = inst_data;
    assign bus.inst_opcode  = inst_data[DW-1:DW-3];
    assign bus.inst_operand = inst_data[AW-1:0];
    assign bus.inst_pc      = inst_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized control traffic,
// every cycle compared against a transaction-level model of the fetch stage.
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       rst, run, redirect_valid;
    logic [4:0] redirect_addr;
    logic [4:0] pc;
    logic [7:0] mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    // model: m_wait = cycles left until the current fetch is presented (0 = none in flight)
    int         m_pc, m_wait, m_ipc;
    bit         m_have, m_live;
    logic [7:0] m_inst;

    instr_fetch_if #(.AW(5), .DW(8)) bus ();

    instr_fetch #(.AW(5), .DW(8), .RESET_PC(5'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pc             (pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_dout <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_pc = 0; m_wait = 0; m_have = 0; m_inst = 8'h00; m_ipc = 0; m_live = 1;
        end else if (redirect_valid) begin
            m_pc   = int'(redirect_addr);
            m_have = 0;
            m_wait = run ? 2 : 0;
        end else if (m_wait == 2) begin
            m_wait = 1;
        end else if (m_wait == 1) begin
            m_inst = mem[m_pc];
            m_ipc  = m_pc;
            m_pc   = (m_pc + 1) % 32;
            m_have = 1;
            m_wait = 0;
        end else if (m_have) begin
            if (bus.inst_ready) begin
                m_have = 0;
                m_wait = run ? 2 : 0;
            end
        end else if (run) begin
            m_wait = 2;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_live) begin
            check("m_mem_en",   {31'd0, bus.mem_en},     {31'd0, m_wait == 2});
            check("m_mem_we",   {31'd0, bus.mem_we},     32'd0);
            check("m_mem_addr", {27'd0, bus.mem_addr},   m_pc);
            check("m_pc",       {27'd0, pc},             m_pc);
            check("m_valid",    {31'd0, bus.inst_valid}, {31'd0, m_have});
            check("m_data",     {24'd0, bus.inst_data},  {24'd0, m_inst});
            check("m_inst_pc",  {27'd0, bus.inst_pc},    m_ipc);
            check("m_opcode",   {29'd0, bus.inst_opcode},  {24'd0, m_inst} >> 5);
            check("m_operand",  {27'd0, bus.inst_operand}, {24'd0, m_inst} & 32'd31);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        m_live = 0; m_pc = 0; m_wait = 0; m_have = 0; m_inst = 8'h00; m_ipc = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hAA; mem[1] = 8'h55; mem[5] = 8'hC5; mem[31] = 8'h1F;
        rst = 1; run = 0; redirect_valid = 0; redirect_addr = 0; bus.inst_ready = 0;

        // reset
        tick(); tick();
        check("rst_valid",   {31'd0, bus.inst_valid}, 32'd0);
        check("rst_pc",      {27'd0, pc},             32'd0);
        check("rst_mem_en",  {31'd0, bus.mem_en},     32'd0);
        check("rst_addr",    {27'd0, bus.mem_addr},   32'd0);
        check("rst_data",    {24'd0, bus.inst_data},  32'd0);
        check("rst_inst_pc", {27'd0, bus.inst_pc},    32'd0);

        // first fetch
        rst = 0; run = 1; bus.inst_ready = 1;
        tick();
        check("f0_mem_en", {31'd0, bus.mem_en},   32'd1);
        check("f0_addr",   {27'd0, bus.mem_addr}, 32'd0);
        bus.inst_ready = 0;
        tick();
        check("f0_cap_en", {31'd0, bus.mem_en},   32'd0);
        tick();
        check("f0_valid",   {31'd0, bus.inst_valid},   32'd1);
        check("f0_data",    {24'd0, bus.inst_data},    32'hAA);
        check("f0_opcode",  {29'd0, bus.inst_opcode},  32'd5);
        check("f0_operand", {27'd0, bus.inst_operand}, 32'h0A);
        check("f0_inst_pc", {27'd0, bus.inst_pc},      32'd0);

        // backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid",   {31'd0, bus.inst_valid}, 32'd1);
            check("bp_data",    {24'd0, bus.inst_data},  32'hAA);
            check("bp_inst_pc", {27'd0, bus.inst_pc},    32'd0);
            check("bp_mem_en",  {31'd0, bus.mem_en},     32'd0);
            check("bp_pc",      {27'd0, pc},             32'd1);
        end
        bus.inst_ready = 1;
        tick();
        check("f1_mem_en", {31'd0, bus.mem_en},   32'd1);
        check("f1_addr",   {27'd0, bus.mem_addr}, 32'd1);
        tick();

        // redirect during CAPTURE of addr1
        redirect_valid = 1; redirect_addr = 5'd5;
        tick();
        redirect_valid = 0;
        check("rd_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rd_addr",  {27'd0, bus.mem_addr},   32'd5);
        tick(); tick();
        check("rd_data",    {24'd0, bus.inst_data}, 32'hC5);
        check("rd_inst_pc", {27'd0, bus.inst_pc},   32'd5);
        check("rd_pc",      {27'd0, pc},            32'd6);

        // wrap: redirect to 31 coincident with handshake
        redirect_valid = 1; redirect_addr = 5'd31;
        tick();
        redirect_valid = 0;
        tick(); tick();
        check("wr_data",    {24'd0, bus.inst_data}, 32'h1F);
        check("wr_inst_pc", {27'd0, bus.inst_pc},   32'd31);
        check("wr_pc",      {27'd0, pc},            32'd0);
        tick(); tick(); tick();
        check("wr2_data",    {24'd0, bus.inst_data}, 32'hAA);
        check("wr2_inst_pc", {27'd0, bus.inst_pc},   32'd0);

        // run dropped during FETCH of addr2
        tick(); tick(); tick();
        check("a1_data", {24'd0, bus.inst_data}, 32'h55);
        tick();
        check("a2_addr", {27'd0, bus.mem_addr}, 32'd2);
        run = 0;
        tick(); tick();
        check("a2_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("a2_data",  {24'd0, bus.inst_data},  {24'd0, mem[2]});
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stop_mem_en", {31'd0, bus.mem_en},     32'd0);
            check("stop_valid",  {31'd0, bus.inst_valid}, 32'd0);
            check("stop_pc",     {27'd0, pc},             32'd3);
        end

        // reset overrides redirect in VALID
        run = 1; bus.inst_ready = 0;
        tick(); tick(); tick();
        check("rv_valid", {31'd0, bus.inst_valid}, 32'd1);
        rst = 1; redirect_valid = 1; redirect_addr = 5'd9;
        tick();
        rst = 0; redirect_valid = 0;
        check("rr_valid",  {31'd0, bus.inst_valid}, 32'd0);
        check("rr_pc",     {27'd0, pc},             32'd0);
        check("rr_mem_en", {31'd0, bus.mem_en},     32'd0);

        // randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            run            = ($urandom_range(0, 9) != 0);
            bus.inst_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_addr  = 5'($urandom);
            tick();
        end
        rst = 0; redirect_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
